// File: rtl/arbiter_mux_if.sv
// Handshake bundle for arbiter_mux: flattened producer inputs, select controls
// and the registered downstream channel.
interface arbiter_mux_if #(
  parameter int WIDTH      = 3,
  parameter int CHANNELS   = 8,
  parameter int SEL_LENGTH = 4
) ();
  logic [WIDTH*CHANNELS-1:0] in_bus;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_LENGTH-1:0]     sel;
  logic                      mode;
  logic [WIDTH-1:0]          out;
  logic [SEL_LENGTH-1:0]     out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_bus, in_valid, sel, mode, out_ready,
    input  in_ready, out, out_chan, out_valid
  );

  modport slave (
    input  in_bus, in_valid, sel, mode, out_ready,
    output in_ready, out, out_chan, out_valid
  );
endinterface

// File: rtl/arbiter_mux.sv
// Registered N-channel mux with fixed-select or round-robin arbitration and
// valid/ready backpressure. Optional handshake counter: ARBITER_MUX_COUNT_EN.
module arbiter_mux #(
  parameter int WIDTH      = 3,
  parameter int CHANNELS   = 8,
  parameter int SEL_LENGTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  arbiter_mux_if.slave bus
`ifdef ARBITER_MUX_COUNT_EN
  ,
  output logic [15:0]  grant_count
`endif
);

  logic [SEL_LENGTH-1:0] ptr_r;
  logic [WIDTH-1:0]      out_r;
  logic [SEL_LENGTH-1:0] out_chan_r;
  logic                  out_valid_r;
  logic                  load_s;
  logic                  grant_valid_s;
  logic [SEL_LENGTH-1:0] grant_idx_s;
  logic [WIDTH-1:0]      data_s;
  logic [CHANNELS-1:0]   in_ready_s;
  int                    best_dist_s;

  assign load_s = !out_valid_r || bus.out_ready;

  // Grant decision; round-robin picks the valid channel nearest after ptr_r.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    best_dist_s   = CHANNELS;
    if (bus.mode == 1'b0) begin
      for (int i = 0; i < CHANNELS; i++) begin
        grant_valid_s = grant_valid_s || ((int'(bus.sel) == i) && bus.in_valid[i]);
        grant_idx_s   = ((int'(bus.sel) == i) && bus.in_valid[i]) ? SEL_LENGTH'(i) : grant_idx_s;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.in_valid[i] && (((i + CHANNELS - 1 - int'(ptr_r)) % CHANNELS) < best_dist_s)) begin
          best_dist_s   = (i + CHANNELS - 1 - int'(ptr_r)) % CHANNELS;
          grant_valid_s = 1'b1;
          grant_idx_s   = SEL_LENGTH'(i);
        end else begin
          best_dist_s   = best_dist_s;
        end
      end
    end
  end

  // Data select and one-hot accept for the granted channel.
  always_comb begin
    data_s     = '0;
    in_ready_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      data_s        = (grant_idx_s == SEL_LENGTH'(i)) ? bus.in_bus[i*WIDTH +: WIDTH] : data_s;
      in_ready_s[i] = !rst && load_s && grant_valid_s && (grant_idx_s == SEL_LENGTH'(i));
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out       = out_r;
  assign bus.out_chan  = out_chan_r;
  assign bus.out_valid = out_valid_r;

  // Output register and round-robin pointer; a stalled word is held untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r       <= '0;
      out_chan_r  <= '0;
      out_valid_r <= 1'b0;
      ptr_r       <= SEL_LENGTH'(CHANNELS - 1);
    end else if (load_s) begin
      if (grant_valid_s) begin
        out_r       <= data_s;
        out_chan_r  <= grant_idx_s;
        out_valid_r <= 1'b1;
        if (bus.mode == 1'b1) begin
          ptr_r <= grant_idx_s;
        end else begin
          ptr_r <= ptr_r;
        end
      end else begin
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef ARBITER_MUX_COUNT_EN
  logic [15:0] grant_count_r;

  // Saturating count of downstream handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count_r <= 16'd0;
    end else if (out_valid_r && bus.out_ready && (grant_count_r != 16'hFFFF)) begin
      grant_count_r <= grant_count_r + 16'd1;
    end else begin
      grant_count_r <= grant_count_r;
    end
  end

  assign grant_count = grant_count_r;
`endif

endmodule

// File: tb/tb_arbiter_mux.sv
// Randomized self-checking bench for arbiter_mux against a transaction-level
// reference model (grant search, output register, pointer).
module tb_arbiter_mux;
  localparam int W  = 3;
  localparam int CH = 8;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // reference model state
  logic [W-1:0]  out_m;
  int            chan_m;
  logic          valid_m;
  int            ptr_m;
  int            cnt_m;

  arbiter_mux_if #(.WIDTH(W), .CHANNELS(CH), .SEL_LENGTH(SL)) intf ();

`ifdef ARBITER_MUX_COUNT_EN
  logic [15:0] grant_count;
`endif

  arbiter_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_LENGTH(SL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(intf)
`ifdef ARBITER_MUX_COUNT_EN
    ,
    .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: check accept at negedge, advance model at the edge, check outputs.
  task automatic step();
    logic          g_ok;
    int            g;
    int            c;
    logic          load_m;
    logic [CH-1:0] exp_rdy;
    logic [CH-1:0] v;
    logic          rst_c;
    logic          ordy_c;
    logic          mode_c;
    logic [W*CH-1:0] bus_c;
    @(negedge clk);
    v = intf.in_valid;
    g_ok = 1'b0;
    g = 0;
    if (intf.mode == 1'b0) begin
      if ((int'(intf.sel) < CH) && v[intf.sel]) begin
        g_ok = 1'b1;
        g = int'(intf.sel);
      end
    end else begin
      for (int k = 1; k <= CH; k++) begin
        c = (ptr_m + k) % CH;
        if (!g_ok && v[c]) begin
          g_ok = 1'b1;
          g = c;
        end
      end
    end
    load_m = !valid_m || intf.out_ready;
    exp_rdy = '0;
    if (!rst && g_ok && load_m) exp_rdy[g] = 1'b1;
    check_eq("in_ready", 32'(intf.in_ready), 32'(exp_rdy));
    rst_c  = rst;
    ordy_c = intf.out_ready;
    mode_c = intf.mode;
    bus_c  = intf.in_bus;
    @(posedge clk);
    #1;
    if (rst_c) begin
      out_m = '0; chan_m = 0; valid_m = 1'b0; ptr_m = CH - 1; cnt_m = 0;
    end else begin
      if (valid_m && ordy_c && cnt_m < 65535) cnt_m++;
      if (load_m) begin
        if (g_ok) begin
          out_m = bus_c[g*W +: W];
          chan_m = g;
          valid_m = 1'b1;
          if (mode_c) ptr_m = g;
        end else begin
          valid_m = 1'b0;
        end
      end
    end
    check_eq("out", 32'(intf.out), 32'(out_m));
    check_eq("out_chan", 32'(intf.out_chan), 32'(chan_m));
    check_eq("out_valid", 32'(intf.out_valid), 32'(valid_m));
`ifdef ARBITER_MUX_COUNT_EN
    check_eq("grant_count", 32'(grant_count), 32'(cnt_m));
`endif
  endtask

  int rr_exp1 [6] = '{1, 4, 7, 1, 4, 7};
  int rr_exp2 [4] = '{1, 7, 1, 7};

  initial begin
    out_m = '0; chan_m = 0; valid_m = 1'b0; ptr_m = CH - 1; cnt_m = 0;
    rst = 1'b1;
    intf.in_bus    = 24'($urandom);
    intf.in_valid  = 8'hFF;
    intf.out_ready = 1'b1;
    intf.mode      = 1'b1;
    intf.sel       = 4'd0;

    // reset held for two cycles
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("first_rr_grant", 32'(intf.out_chan), 32'd0);

    // fixed select of channel 2
    intf.mode = 1'b0;
    intf.sel  = 4'd2;
    intf.in_bus = 24'($urandom);
    intf.in_bus[8:6] = 3'b101;
    step();
    check_eq("fixed_out", 32'(intf.out), 32'd5);
    check_eq("fixed_chan", 32'(intf.out_chan), 32'd2);
    step();

    // out-of-range select never grants
    intf.sel = 4'd9;
    step();
    check_eq("oor_valid", 32'(intf.out_valid), 32'd0);
    step();

    // round-robin over channels 1,4,7 then without 4
    intf.mode = 1'b1;
    intf.in_valid = 8'b10010010;
    for (int k = 0; k < 6; k++) begin
      intf.in_bus = 24'($urandom);
      step();
      check_eq("rr_seq", 32'(intf.out_chan), 32'(rr_exp1[k]));
    end
    intf.in_valid = 8'b10000010;
    for (int k = 0; k < 4; k++) begin
      intf.in_bus = 24'($urandom);
      step();
      check_eq("rr_drop", 32'(intf.out_chan), 32'(rr_exp2[k]));
    end

    // backpressure: three stalled cycles then release
    intf.in_valid = 8'hFF;
    intf.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      intf.in_bus = 24'($urandom);
      step();
    end
    intf.out_ready = 1'b1;
    step();
    check_eq("bp_refill_valid", 32'(intf.out_valid), 32'd1);

    // randomized traffic with occasional reset
    for (int k = 0; k < 600; k++) begin
      intf.in_bus    = 24'($urandom);
      intf.in_valid  = 8'($urandom);
      intf.sel       = 4'($urandom_range(0, 15));
      intf.mode      = ($urandom_range(0, 3) != 0);
      intf.out_ready = ($urandom_range(0, 3) != 0);
      rst            = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbiter_mux.md
# arbiter_mux

Registered, parametrised N-channel multiplexer with valid/ready handshaking and two selection modes: fixed (external `sel`) and round-robin. It is the sequential successor to the combinational `in_bus`/`sel`/`out` channel mux in the ALU datapath. It sits between multiple operand or result producers and a single downstream consumer. It adds arbitration, backpressure and a one-cycle output register to the plain flattened-bus select.

## Interface
Parameters:
- `WIDTH`, 3: bits per channel.
- `CHANNELS`, 8: number of input channels (>=2).
- `SEL_LENGTH`, 4: width of `sel`/`out_chan`; must satisfy 2^SEL_LENGTH >= CHANNELS.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_bus`  in  WIDTH*CHANNELS  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  CHANNELS  per-channel data valid.
- `in_ready`  out  CHANNELS  per-channel accept; at most one bit high (one-hot or zero).
- `sel`  in  SEL_LENGTH  channel index used in fixed mode.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `out`  out  WIDTH  registered selected data.
- `out_chan`  out  SEL_LENGTH  index of the channel that produced `out`.
- `out_valid`  out  1  `out`/`out_chan` hold an unconsumed transfer.
- `out_ready`  in  1  downstream accepts when high with `out_valid`.

## Operation
- `load = !out_valid || out_ready`: output register may take new data this cycle.
- Grant, fixed mode: channel `sel` if `sel < CHANNELS` and `in_valid[sel]`; otherwise no grant. Out-of-range `sel` never grants and never wraps.
- Grant, round-robin mode: first channel with `in_valid` set, searching cyclically from `ptr+1` through `ptr`.
- `in_ready[g] = load` for granted channel g; all other bits are 0.
- Transfer occurs when `in_valid[g] && in_ready[g]`. On the next edge: `out <= in_bus[g]`, `out_chan <= g`, `out_valid <= 1`. In round-robin mode, `ptr <= g`.
- `load` with no grant: `out_valid <= 0`; `out`/`out_chan` hold their old values.
- `out_valid && !out_ready`: `out`, `out_chan` and `out_valid` are held stable; `in_ready = 0`.
- `ptr` updates only on round-robin transfers. Fixed-mode transfers leave it unchanged.
- Mode or `sel` changes take effect on the next grant decision. There is no flush and no lost transfer.
- Reset values: `out=0`, `out_chan=0`, `out_valid=0`, `ptr=CHANNELS-1` (channel 0 wins first), `in_ready=0` while `rst` is high.
- Reset during a stalled transfer discards it; the upstream producer does not see a false accept.

## Timing
- Latency: 1 cycle from input accept to `out_valid`.
- Throughput: 1 transfer per cycle with `out_ready` held high. Drain and refill in the same cycle, no bubble.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `sel`, `mode` and `ptr`. There is no combinational path from `in_bus` to any output.
- `out`, `out_chan` and `out_valid` are driven directly from flops.
- Round-robin fairness: any continuously valid channel is granted within CHANNELS consecutive transfers.

## Configuration
- `ARBITER_MUX_COUNT_EN` defined:
  - Adds output port `grant_count` (16 bits).
  - It increments on every downstream handshake (`out_valid && out_ready`) and saturates at 16'hFFFF.
  - Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
Default parameters (3/8/4) unless noted.
- Reset: `rst=1` for 2 cycles with `in_valid=8'hFF`, `out_ready=1` -> `in_ready=0`, `out_valid=0`, `out=0`, `out_chan=0` every cycle. First round-robin grant after release is channel 0.
- Fixed mode: `sel=4'd2`, channel 2 data=3'b101, `in_valid=8'hFF`, `out_ready=1` -> `in_ready=8'b00000100` each cycle; next cycle `out=3'b101`, `out_chan=2`, `out_valid=1`.
- Fixed mode out of range: `sel=4'd9`, `in_valid=8'hFF` -> `in_ready=0`; `out_valid` falls to 0 one cycle after the last held transfer drains.
- Round-robin: `in_valid=8'b10010010`, `out_ready=1` -> `out_chan` sequence 1,4,7,1,4,7. Dropping `in_valid[4]` mid-sequence gives 1,7,1,7.
- Backpressure: `out_valid=1`, `out_ready=0` for 3 cycles -> `out`/`out_chan` stable, `in_ready=0`. Raising `out_ready` accepts the next grant in that cycle, and the new `out` appears with no idle cycle.
- With `ARBITER_MUX_COUNT_EN`: 10 downstream handshakes -> `grant_count=10`; `rst` pulse -> 0. A saturation check preloaded near the limit holds at 16'hFFFF.
